// File: rtl/lockcomp.sv
// lockcomp: programmable 16-bit code register with a registered exact-match flag.
module lockcomp #(
  parameter logic [15:0] DEFAULT_CODE = 16'h0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        set,
  input  logic        enable,
  input  logic [15:0] new_code,
  input  logic [15:0] pressed_code,
  output logic        equal
);
  logic [15:0] code_q, code_d;
  logic        equal_q, equal_d;
  always_comb begin
    code_d  = set ? DEFAULT_CODE : enable ? new_code : code_q;
    equal_d = !(set || enable) && (pressed_code == code_q);
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      code_q  <= DEFAULT_CODE;
      equal_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      equal_q <= equal_d;
    end
  end
  assign equal = equal_q;
endmodule

// File: tb/tb_lockcomp.sv
// tb_lockcomp: directed and randomized checks of lockcomp against a behavioural lock model.
module tb_lockcomp;
  localparam logic [15:0] DEF = 16'h0000;
  logic        clk = 1'b0;
  logic        clr, set, enable;
  logic [15:0] new_code, pressed_code;
  logic        equal;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] stored;
  lockcomp #(.DEFAULT_CODE(DEF)) dut (
    .clk(clk), .clr(clr), .set(set), .enable(enable),
    .new_code(new_code), .pressed_code(pressed_code), .equal(equal)
  );
  always #5 clk = ~clk;
  task automatic chk_eq(input logic exp, input string tag);
    checks++;
    assert (equal === exp) else begin
      errors++;
      $error("FAIL %s: equal=%b expected %b", tag, equal, exp);
    end
  endtask
  task automatic chk_code(input logic [15:0] exp, input string tag);
    checks++;
    assert (dut.code_q === exp) else begin
      errors++;
      $error("FAIL %s: code=%h expected %h", tag, dut.code_q, exp);
    end
  endtask
  // One clock: the lock reports a match only when idle and the entry equals the code held before the edge.
  task automatic step(input logic s, input logic en, input logic [15:0] nc, input logic [15:0] pc,
                      input string tag);
    logic exp;
    set = s; enable = en; new_code = nc; pressed_code = pc;
    exp = !s && !en && pc == stored;
    if (s) stored = DEF;
    else if (en) stored = nc;
    @(posedge clk); #1;
    chk_eq(exp, tag);
    chk_code(stored, {tag, "_code"});
  endtask
  task automatic pulse_reset(input string tag);
    #1 clr = 1'b0;
    #1;
    stored = DEF;
    chk_eq(1'b0, tag);
    chk_code(DEF, {tag, "_code"});
    #1 clr = 1'b1;
  endtask
  initial begin
    clr = 1'b0; set = 1'b0; enable = 1'b0; new_code = 16'h0; pressed_code = 16'h0;
    stored = DEF;
    #3;
    chk_eq(1'b0, "reset_eq");
    chk_code(DEF, "reset_code");
    #17 clr = 1'b1;
    step(0, 0, 16'h0000, 16'h0000, "default_match");
    step(0, 1, 16'h1234, 16'h0000, "prog1");
    step(0, 1, 16'h1234, 16'h0000, "prog2");
    step(0, 0, 16'h0000, 16'h0000, "newcode_ignored");
    step(0, 0, 16'hBEEF, 16'h1234, "newcode_ignored2");
    for (int i = 1; i <= 16'h1240; i++) step(0, 0, 16'h5555, 16'(i), "sweep");
    step(0, 1, 16'h1234, 16'h1234, "mask1");
    step(0, 1, 16'h1234, 16'h1234, "mask2");
    step(0, 0, 16'h0000, 16'h1234, "mask_release");
    step(0, 0, 16'h0000, 16'h1234, "match_holds");
    step(1, 0, 16'h0000, 16'h1234, "set_edge");
    step(0, 0, 16'h0000, 16'h1234, "set_old_code");
    step(0, 0, 16'h0000, 16'h0000, "set_default");
    step(0, 0, 16'h0000, 16'h0000, "pre_reset_match");
    pulse_reset("async_reset");
    step(0, 1, 16'hA5A5, 16'h0000, "prog_then_reset");
    pulse_reset("reset_during_prog");
    step(0, 0, 16'h0000, 16'hA5A5, "prog_discarded");
    step(0, 0, 16'h0000, 16'h0000, "after_reset_default");
    step(0, 1, 16'hFFFF, 16'h0000, "prog_ffff");
    step(0, 0, 16'h0000, 16'hFFFF, "match_ffff");
    step(0, 0, 16'h0000, 16'h7FFF, "near_ffff");
    for (int i = 0; i < 400; i++) begin
      logic s, en;
      logic [15:0] pc;
      s  = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) == 0);
      pc = $urandom_range(0, 1) ? stored : 16'($urandom);
      if ($urandom_range(0, 2) == 0) pc = stored ^ (16'h1 << $urandom_range(0, 15));
      step(s, en, 16'($urandom), pc, "rand");
      if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lockcomp.md
LOCKCOMP -- requirements
Module: lockcomp

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port clr, input, 1 bit: the asynchronous, active-low reset.
REQ-003 The block SHALL have the port set, input, 1 bit: synchronous restore of the stored code to the default value.
REQ-004 The block SHALL have the port enable, input, 1 bit: program mode; while high, new_code is captured into the stored code.
REQ-005 The block SHALL have the port new_code, input, 16 bits: the code value to be programmed.
REQ-006 The block SHALL have the port pressed_code, input, 16 bits: the code entered by the user for comparison.
REQ-007 The block SHALL have the port equal, output, 1 bit: registered match flag.
REQ-008 The block SHALL have the parameter DEFAULT_CODE, default 16'h0000: the stored-code value after reset and after set.

Function
REQ-009 The block SHALL contain one 16-bit stored-code register (code_q) and one 1-bit output register (equal).
REQ-010 Stored-code update priority per rising clk edge SHALL be: set=1 -> code_q <= DEFAULT_CODE; else enable=1 -> code_q <= new_code; else hold.
REQ-011 While enable=1, code_q SHALL follow new_code on every edge, so the final value is the one present on the last edge with enable high.
REQ-012 equal SHALL be computed each rising edge as: 0 if enable=1 or set=1, else (pressed_code == code_q), using the pre-edge code_q value.
REQ-013 The comparison SHALL be an exact 16-bit compare; it SHALL apply no masking, partial match or wrap-around semantics.
REQ-014 Latency SHALL be one clock: a change on pressed_code is reflected on equal after the next rising edge.
REQ-015 After enable falls, the first edge with enable=0 SHALL compare against the newly stored code.
REQ-016 There SHALL be no handshake; pressed_code is sampled every cycle, and equal stays high for as long as the match persists.
REQ-017 Changes to new_code while enable=0 and set=0 SHALL have no effect on code_q or equal.
REQ-018 The block SHALL contain no other state machine beyond the two registers.

Reset
REQ-019 While clr=0, code_q SHALL be DEFAULT_CODE and equal SHALL be 0, immediately and independent of clk.
REQ-020 clr deassertion SHALL be synchronized by the user; the first edge after clr rises SHALL perform normal operation.
REQ-021 A reset asserted mid-operation, including during programming, SHALL discard the programmed code and restore DEFAULT_CODE.

Verification
REQ-022 Reset check: clr=0 for 20 ns, then 1 with pressed_code=16'h0000 -> equal=0 during reset, then equal=1 one edge later (default code matches).
REQ-023 Programming check: enable=1, new_code=16'h1234 for 2 edges, enable=0, new_code=16'h0000 -> code_q=16'h1234, and a new_code change after enable falls is ignored.
REQ-024 Sweep check: pressed_code incremented 1,2,3,... each cycle -> equal=0 for all values except 16'h1234, where equal=1 one edge after pressed_code=16'h1234.
REQ-025 Program-mode masking check: pressed_code=16'h1234 held while enable=1 -> equal=0; equal=1 one edge after enable returns to 0.
REQ-026 set check: set=1 for one edge with code 16'h1234 stored -> code_q=DEFAULT_CODE; pressed_code=16'h1234 gives equal=0 and pressed_code=16'h0000 gives equal=1.
REQ-027 Reset-during-match check: equal=1, then clr=0 -> equal=0 immediately without waiting for a clk edge.
